bfm_apb2ahb: RTL

- APB-to-AHB bridge for the AMBA BFM set, the reverse of the AHB-to-APB bridge.
- Acts as an APB slave (completer) and converts each APB access into one AHB-Lite single word transfer as AHB master.
- Lets APB-side BFMs and peripherals reach AHB memory and slaves in testbenches.
- Handles AHB wait states, AHB two-cycle ERROR responses and an optional address-phase timeout.

---
 rtl/bfm_apb2ahb_pkg.sv | 20 ++
 rtl/bfm_apb2ahb.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bfm_apb2ahb_pkg.sv
// rtl/bfm_apb2ahb_pkg.sv - AHB encodings and bridge states shared by the APB-to-AHB BFM
package bfm_apb2ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  localparam int unsigned TCNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR2 = 3'd3,
    ST_RESP = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/bfm_apb2ahb.sv
// rtl/bfm_apb2ahb.sv - APB completer that replays each access as one AHB-Lite single word transfer
module bfm_apb2ahb
  import bfm_apb2ahb_pkg::*;
#(
  parameter int          TPD      = 1,
  parameter logic [31:0] AHB_BASE = 32'h0000_0000,
  parameter int          TIMEOUT  = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  // TPD only shapes simulation timing elsewhere; out-of-range values leave nothing to build.
  if (TPD < 0 || TIMEOUT < 0 || TIMEOUT > 65535) begin : g_param_range_unsupported
  end

  localparam bit                TO_EN   = (TIMEOUT > 0);
  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT - 1);

  bridge_state_t     state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       haddr_d, hwdata_d, prdata_d;
  logic [1:0]        htrans_d;
  logic              hwrite_d, pready_d, pslverr_d;

  logic unused_paddr_lsbs;
  assign unused_paddr_lsbs = ^PADDR[1:0];

  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    wdata_d   = wdata_q;
    haddr_d   = HADDR;
    htrans_d  = HTRANS;
    hwrite_d  = HWRITE;
    hwdata_d  = HWDATA;
    prdata_d  = PRDATA;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a genuine setup phase starts a transfer; PSEL with PENABLE here is ignored.
        if (PSEL && !PENABLE) begin
          hwrite_d = PWRITE;
          wdata_d  = PWDATA;
          haddr_d  = AHB_BASE | {PADDR[31:2], 2'b00};
          htrans_d = HTRANS_NONSEQ;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          tcnt_d   = '0;
          state_d  = ST_DATA;
        end else if (TO_EN && tcnt_q == TO_LAST) begin
          htrans_d  = HTRANS_IDLE;
          tcnt_d    = '0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = ST_RESP;
        end else if (TO_EN) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        // A single-cycle ERROR is not legal AHB but is still reported as an error.
        if (HRESP) begin
          if (HREADY) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_ERR2;
          end
        end else if (HREADY) begin
          if (!HWRITE) prdata_d = HRDATA;
          pready_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_ERR2: begin
        if (HREADY) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      wdata_q <= '0;
      HADDR   <= '0;
      HTRANS  <= HTRANS_IDLE;
      HWRITE  <= 1'b0;
      HWDATA  <= '0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      wdata_q <= wdata_d;
      HADDR   <= haddr_d;
      HTRANS  <= htrans_d;
      HWRITE  <= hwrite_d;
      HWDATA  <= hwdata_d;
      PRDATA  <= prdata_d;
      PREADY  <= pready_d;
      PSLVERR <= pslverr_d;
    end
  end

endmodule
